ysyx_22040237_mem_arb: RTL and testbench

YSYX_22040237_MEM_ARB -- requirements
Module: ysyx_22040237_mem_arb

---
 rtl/ysyx_22040237_mem_arb.sv | 121 ++++++++++++
 tb/tb_ysyx_22040237_mem_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_mem_arb.sv
// Two-requester (IFU/LSU) arbiter onto a single shared memory port, one transaction in flight.
// Define YSYX_22040237_ARB_RR_EN for round-robin contention; otherwise LSU has fixed priority.
module ysyx_22040237_mem_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                grant_lsu
);

  // state | meaning
  // IDLE  | no transaction; accept one requester this cycle
  // REQ   | presenting latched request until mem_req_ready
  // WAIT  | waiting for mem_rsp_valid, routed to the owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic                  grant_lsu_q;
  logic                  pick;
  logic                  pick_lsu;
  logic                  in_req;
  logic                  rsp_fire;

  // rst gates the grant so req_ready stays low while reset is held
  assign pick = rst & (state_q == IDLE) & (ifu_req_valid | lsu_req_valid);

`ifdef YSYX_22040237_ARB_RR_EN
  logic last_lsu_q;

  assign pick_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lsu_q <= 1'b0;
    end else if (pick) begin
      last_lsu_q <= pick_lsu;
    end
  end
`else
  assign pick_lsu = lsu_req_valid;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = WAIT;
      WAIT:    if (mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      grant_lsu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pick) begin
        addr_q      <= pick_lsu ? lsu_req_addr : ifu_req_addr;
        wen_q       <= pick_lsu & lsu_req_wen;
        wdata_q     <= pick_lsu ? lsu_req_wdata : '0;
        wmask_q     <= pick_lsu ? lsu_req_wmask : '0;
        grant_lsu_q <= pick_lsu;
      end
    end
  end

  assign ifu_req_ready = pick & ~pick_lsu;
  assign lsu_req_ready = pick & pick_lsu;

  assign in_req        = (state_q == REQ);
  assign mem_req_valid = in_req;
  assign mem_req_addr  = in_req ? addr_q  : '0;
  assign mem_req_wen   = in_req & wen_q;
  assign mem_req_wdata = in_req ? wdata_q : '0;
  assign mem_req_wmask = in_req ? wmask_q : '0;

  // responses outside WAIT belong to nobody (e.g. left over from an abandoned transaction)
  assign rsp_fire      = (state_q == WAIT) & mem_rsp_valid;
  assign ifu_rsp_valid = rsp_fire & ~grant_lsu_q;
  assign lsu_rsp_valid = rsp_fire & grant_lsu_q;
  assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
  assign lsu_rsp_data  = lsu_rsp_valid ? mem_rsp_data : '0;
  assign grant_lsu     = grant_lsu_q;

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// Scoreboard bench for ysyx_22040237_mem_arb: requester/memory models drive the DUT,
// expected responses are queued at request acceptance and popped when the DUT responds.
module tb_ysyx_22040237_mem_arb;

`ifdef YSYX_22040237_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [7:0]  mem_req_wmask;
  logic        grant_lsu;

  always #5 clk = ~clk;

  ysyx_22040237_mem_arb #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .grant_lsu(grant_lsu)
  );

  typedef struct packed {
    logic        lsu;
    logic [63:0] data;
  } sb_t;

  sb_t sb_q[$];
  bit  grant_log[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;

  int          ifu_left, lsu_left;
  logic [63:0] ifu_addr, lsu_addr, lsu_wdata;
  logic        lsu_wen;
  logic [7:0]  lsu_wmask;

  int          rdy_wait, rdy_cnt, rsp_lat, rsp_cnt;
  bit          rsp_pend, stray_rsp, late_seen;
  logic [63:0] rsp_dat;

  int          m_state;
  bit          m_last_lsu;
  bit          cur_lsu, cur_wen;
  logic [63:0] cur_addr, cur_wdata;
  logic [7:0]  cur_wmask;
  int          stall_cnt, t_acc, t_hs, t_rsp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0413;
    return a ^ 64'h5A5A_0000_1234_0000;
  endfunction

  function automatic logic [7:0] log_bits();
    logic [7:0] v = '0;
    for (int i = 0; i < grant_log.size() && i < 8; i++) v[7-i] = grant_log[i];
    return v;
  endfunction

  task automatic sample_check();
    bit         any, win_lsu, rsp_v;
    logic [1:0] exp_rdy, exp_rv;
    sb_t        e;
    any = (m_state == 0) && (ifu_left > 0 || lsu_left > 0);
    if (ifu_left > 0 && lsu_left > 0) win_lsu = RR ? !m_last_lsu : 1'b1;
    else win_lsu = (lsu_left > 0);
    exp_rdy = !any ? 2'b00 : (win_lsu ? 2'b01 : 2'b10);
    chk("req_ready", {ifu_req_ready, lsu_req_ready}, exp_rdy);

    chk("mem_req_valid", mem_req_valid, m_state == 1);
    if (m_state == 1) begin
      chk("mem_addr", mem_req_addr, cur_addr);
      chk("mem_wen", mem_req_wen, cur_wen);
      chk("mem_wdata", mem_req_wdata, cur_wdata);
      chk("mem_wmask", mem_req_wmask, cur_wmask);
      if (!mem_req_ready) stall_cnt++;
    end else begin
      chk("mem_fields_zero", mem_req_addr | mem_req_wdata | {55'b0, mem_req_wen, mem_req_wmask}, 0);
    end
    if (m_state != 0) chk("grant_lsu", grant_lsu, cur_lsu);

    rsp_v  = (m_state == 2) && mem_rsp_valid;
    exp_rv = rsp_v ? (cur_lsu ? 2'b01 : 2'b10) : 2'b00;
    chk("rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, exp_rv);
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      if (sb_q.size() == 0) chk("sb_nonempty", sb_q.size(), 1);
      else begin
        e = sb_q.pop_front();
        chk("rsp_owner", lsu_rsp_valid, e.lsu);
        chk("rsp_data", lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data, e.data);
        t_rsp = cyc;
      end
    end
    chk("nonowner_data", (ifu_rsp_valid ? 64'h0 : ifu_rsp_data) | (lsu_rsp_valid ? 64'h0 : lsu_rsp_data), 0);

    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        rsp_pend = 1'b0;
        if (m_state != 2) late_seen = 1'b1;
      end else rsp_cnt--;
    end

    case (m_state)
      0: if (any) begin
        if (win_lsu) begin
          cur_lsu = 1'b1; cur_addr = lsu_addr; cur_wen = lsu_wen;
          cur_wdata = lsu_wdata; cur_wmask = lsu_wmask;
          sb_q.push_back('{lsu: 1'b1, data: mem_data(lsu_addr)});
          lsu_left--; lsu_addr += 8; lsu_wdata += 1;
        end else begin
          cur_lsu = 1'b0; cur_addr = ifu_addr; cur_wen = 1'b0;
          cur_wdata = '0; cur_wmask = '0;
          sb_q.push_back('{lsu: 1'b0, data: mem_data(ifu_addr)});
          ifu_left--; ifu_addr += 4;
        end
        m_last_lsu = win_lsu;
        grant_log.push_back(win_lsu);
        t_acc = cyc;
        m_state = 1;
      end
      1: if (mem_req_ready) begin
        m_state = 2; rsp_pend = 1'b1; rsp_cnt = rsp_lat;
        rsp_dat = mem_data(cur_addr); rdy_cnt = rdy_wait; t_hs = cyc;
      end else if (rdy_cnt > 0) rdy_cnt--;
      2: if (mem_rsp_valid) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  // called at posedge+1: drive, sample at negedge, advance to next posedge+1
  task automatic step();
    bit real_rsp;
    real_rsp      = rsp_pend && rsp_cnt == 0;
    ifu_req_valid = ifu_left > 0;
    ifu_req_addr  = ifu_addr;
    lsu_req_valid = lsu_left > 0;
    lsu_req_addr  = lsu_addr;
    lsu_req_wen   = lsu_wen;
    lsu_req_wdata = lsu_wdata;
    lsu_req_wmask = lsu_wmask;
    mem_req_ready = (rdy_cnt == 0);
    mem_rsp_valid = real_rsp || (stray_rsp && m_state != 2);
    mem_rsp_data  = real_rsp ? rsp_dat : 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    sample_check();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int max);
    int  n = 0;
    bit  done;
    do begin
      step();
      n++;
      done = (m_state == 0) && ifu_left == 0 && lsu_left == 0 && !rsp_pend;
    end while (!done && n < max);
    chk("idle_timeout", done, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    #1;
    chk("rst_ctl", {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
                    mem_req_valid, mem_req_wen, grant_lsu}, 0);
    chk("rst_data", ifu_rsp_data | lsu_rsp_data | mem_req_addr | mem_req_wdata | {56'b0, mem_req_wmask}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl_hold", {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
                         mem_req_valid, mem_req_wen, grant_lsu}, 0);
    m_state = 0; m_last_lsu = 1'b0; sb_q.delete();
    rdy_cnt = rdy_wait;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifu_left = 0; lsu_left = 0; ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0;
    lsu_wen = 1'b0; lsu_wmask = '0;
    rdy_wait = 0; rdy_cnt = 0; rsp_lat = 1; rsp_cnt = 0;
    rsp_pend = 1'b0; stray_rsp = 1'b0; late_seen = 1'b0; rsp_dat = '0;
    m_state = 0; m_last_lsu = 1'b0; cur_lsu = 1'b0; cur_wen = 1'b0;
    cur_addr = '0; cur_wdata = '0; cur_wmask = '0;
    stall_cnt = 0; t_acc = 0; t_hs = -100; t_rsp = -100;
    rst = 1'b0;
    ifu_req_addr = '0; lsu_req_addr = '0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_rsp_data = '0;
    @(posedge clk); #1;
    apply_reset();

    // single IFU fetch, response two cycles after handshake
    ifu_addr = 64'h8000_0000; ifu_left = 1;
    run_until_idle(20);
    chk("fetch_hs_latency", t_hs - t_acc, 1);
    chk("fetch_rsp_latency", t_rsp - t_acc, 3);

    // contention: LSU store first, IFU on the next IDLE
    grant_log.delete();
    ifu_addr = 64'h8000_0100; ifu_left = 1;
    lsu_addr = 64'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 64'h55; lsu_wmask = 8'h01; lsu_left = 1;
    run_until_idle(40);
    chk("contend_grants", {grant_log.size(), log_bits()}, {32'd2, 8'b1000_0000});

    // continuous contention over 8 transactions from reset
    apply_reset();
    grant_log.delete();
    rsp_lat = 0; lsu_wen = 1'b0; lsu_wmask = 8'hFF; lsu_wdata = 64'h1234;
    ifu_addr = 64'h8000_2000; lsu_addr = 64'h8000_3000;
    ifu_left = 4; lsu_left = 4;
    run_until_idle(100);
    chk("grant_seq", log_bits(), RR ? 8'b1010_1010 : 8'b1111_0000);

    // back-pressure: ready low 5 cycles per transaction, stray responses ignored
    rdy_wait = 5; rdy_cnt = 5; stall_cnt = 0; stray_rsp = 1'b1; rsp_lat = 2;
    lsu_wen = 1'b1; lsu_wmask = 8'h0F; lsu_addr = 64'h8000_4000;
    ifu_addr = 64'h8000_5000; ifu_left = 1; lsu_left = 1;
    run_until_idle(80);
    chk("stall_cycles", stall_cnt, 10);
    stray_rsp = 1'b0; rdy_wait = 0; rdy_cnt = 0;

    // reset during WAIT; the late response must be dropped
    rsp_lat = 4; lsu_addr = 64'h8000_6000; lsu_left = 1; late_seen = 1'b0;
    begin
      int n = 0;
      while (m_state != 2 && n < 10) begin step(); n++; end
      chk("reached_wait", m_state, 2);
    end
    apply_reset();
    chk("grant_after_rst", grant_lsu, 0);
    repeat (8) step();
    chk("late_rsp_driven", late_seen, 1);

    // stray response while IDLE, then a normal fetch to confirm recovery
    stray_rsp = 1'b1;
    repeat (3) step();
    stray_rsp = 1'b0;
    rsp_lat = 2; ifu_addr = 64'h8000_7000; ifu_left = 1;
    run_until_idle(20);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
